dff_reg: RTL and testbench

Parameterized positive-edge pipeline register. It captures a WIDTH-bit data word on every rising clock edge, with synchronous active-high reset to a constant value. It is the basic state element between pipeline stages of the RISC-V CPU (PC register, stage latches). An optional hold-enable can be compiled in for stall support.

---
 rtl/dff_reg.sv | 61 ++++++
 tb/tb_dff_reg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dff_reg.sv
// dff_reg: parameterized positive-edge pipeline register.
//
// Captures a WIDTH-bit word on every rising edge of clk. A synchronous,
// active-high reset loads RESET_VAL. This is the basic state element between
// pipeline stages (PC register, stage latches).
//
// Optional feature (compile-time macro DFF_HOLD_EN):
//   When defined, an extra input 'en' is present. With en low and reset low,
//   the register holds its value (stall). Reset always wins over en.
//   When undefined, there is no en port and the register loads d on every
//   non-reset edge.
//
// Parameters:
//   WIDTH      data width in bits (>= 1)
//   RESET_VAL  value loaded into q on reset
//
// Ports:
//   clk    input   1      clock, rising edge only
//   reset  input   1      synchronous active-high reset
//   d      input   WIDTH  data to capture
//   q      output  WIDTH  registered data
//   en     input   1      hold-enable (only with DFF_HOLD_EN)

module dff_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DFF_HOLD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state data path, excluding reset.
  always_comb begin
    q_d = d;
`ifdef DFF_HOLD_EN
    if (!en) begin
      q_d = q_q;
    end
`endif
  end

  // 'if (reset)' form: an X or undriven reset does not block loading d.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff_reg.sv
// Self-checking bench for dff_reg: a behavioural model plus a per-cycle
// compare process, and literal expectations at fixed times.
module tb_dff_reg;

  localparam int unsigned    W    = 32;
  localparam logic [W-1:0]   RVAL = '0;

  logic         clk;
  logic         reset;
  logic [W-1:0] d;
  logic [W-1:0] q;
`ifdef DFF_HOLD_EN
  logic         en;
`endif

  int checks;
  int errors;

  dff_reg #(
    .WIDTH     (W),
    .RESET_VAL (RVAL)
  ) u_dut (
    .clk   (clk),
`ifdef DFF_HOLD_EN
    .en    (en),
`endif
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: what q must be after the most recent rising edge.
  logic [W-1:0] model_q;
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model_q     <= RVAL;
      model_valid <= 1'b1;
`ifdef DFF_HOLD_EN
    end else if (en !== 1'b1) begin
      model_q     <= model_q;
`endif
    end else begin
      model_q     <= d;
      model_valid <= 1'b1;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (q !== model_q) begin
        errors++;
        $display("FAIL model t=%0t q=%h expected=%h", $time, q, model_q);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] exp);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s t=%0t q=%h expected=%h", name, $time, q, exp);
    end
  endtask

  task automatic at(input int t);
    #(t - $time);
  endtask

  initial begin
    // Reset deliberately left undriven at the start.
    d = 32'h9e3b;
`ifdef DFF_HOLD_EN
    en = 1'b1;
`endif
    at(7);   check("load_undriven_reset", 32'h9e3b);
    at(10);  d = 32'hdcc8;
    at(17);  check("data_change", 32'hdcc8);
    at(27);  check("data_held", 32'hdcc8);
    at(30);  reset = 1'b1;
    at(31);  check("reset_not_async_31", 32'hdcc8);
    at(34);  check("reset_not_async_34", 32'hdcc8);
    at(37);  check("sync_reset", RVAL);
    at(40);  reset = 1'b0; d = 32'h34d3;
    at(47);  check("reset_release", 32'h34d3);
    at(50);  d = 32'h1b3c;
    at(57);  check("post_release_load", 32'h1b3c);
    // Glitch d between edges.
    at(60);  d = 32'h1111;
    at(61);  d = 32'h2222;
    at(62);  d = 32'h3333;
    at(63);  check("d_glitch_no_effect", 32'h1b3c);
    at(67);  check("d_glitch_last_value", 32'h3333);
    // Reset pulse between edges.
    at(70);  reset = 1'b1;
    at(71);  reset = 1'b0;
    at(72);  check("reset_pulse_no_effect", 32'h3333); d = 32'h4444;
    at(77);  check("after_reset_pulse", 32'h4444);
    // Reset held for several cycles while d keeps moving.
    at(80);  reset = 1'b1; d = 32'hffff_ffff;
    at(87);  check("reset_held_1", RVAL);
    at(90);  d = 32'h1234_5678;
    at(97);  check("reset_held_2", RVAL);
    at(100); d = 32'h8000_0001;
    at(107); check("reset_held_3", RVAL);
    at(110); reset = 1'b0; d = 32'h5a5a_a5a5;
    at(117); check("release_full_width", 32'h5a5a_a5a5);
`ifdef DFF_HOLD_EN
    at(120); en = 1'b0; d = 32'hAAAA;
    at(127); check("hold_en0", 32'h5a5a_a5a5);
    at(130); reset = 1'b1;
    at(137); check("reset_overrides_en0", RVAL);
    at(140); reset = 1'b0;
    at(147); check("hold_en0_after_reset", RVAL);
    at(150); en = 1'b1;
    at(157); check("en1_load", 32'hAAAA);
`else
    at(120); d = 32'hAAAA;
    at(127); check("always_load", 32'hAAAA);
    at(130); d = 32'h0000_0001;
    at(137); check("always_load_lsb", 32'h0000_0001);
`endif
    at(162);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
